dmem_responder: RTL and testbench

Data-memory responder for the pipelined CPU's load/store port. It accepts one request at a time over a valid/ready handshake and serves it from an internal word-addressed array after a programmable number of wait states. It returns read data or a write acknowledge, with an error flag, over a second valid/ready channel. It lets the CPU's memory stage be exercised against a non-zero-latency slave in place of the combinational data memory.

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states,
// word-addressed array with byte-lane stores and an error flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           mem [DEPTH_WORDS];

    logic                  accept;
    logic                  go_resp;
    logic                  a_we;
    logic                  a_bad;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [31:0]           a_wdata;
    logic [3:0]            a_wstrb;
    logic [IW-1:0]         a_idx;

    assign accept = (state == IDLE) && req_valid && req_ready;

    // With zero wait states the access happens on the accept edge itself,
    // so the request is taken straight from the port instead of the capture.
    always_comb begin
        a_we    = we_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_wstrb = wstrb_q;
        if (state == IDLE) begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_wstrb = req_wstrb;
        end
        a_idx   = a_addr[IW+1:2];
        a_bad   = (a_addr[1:0] != 2'b00) || ({1'b0, a_addr} >= LIMIT);
        go_resp = !reset && ((accept && (LATENCY == 0)) ||
                             ((state == WAIT) && (cnt == 4'd0)));
    end

    always_ff @(posedge clk) begin
        if (go_resp && a_we && !a_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (a_wstrb[i]) begin
                    mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= a_bad;
                rsp_rdata <= (a_we || a_bad) ? 32'd0 : mem[a_idx];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a transaction-level model,
// plus directed checks including a zero-latency instance.
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_we, b_rsp_ready;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_WIDTH(32)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .ADDR_WIDTH(32)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a request is answered LAT edges after its
    // accept edge, the array is touched on that edge, and the slave is
    // ready again the cycle after the response handshake.
    bit [31:0] m_mem [DEPTH];
    bit        m_pend, m_rv, m_ready, m_err, m_busy;
    bit [31:0] m_rdata;
    int        m_at;
    bit        m_we;
    bit [31:0] m_addr, m_wdata;
    bit [3:0]  m_wstrb;

    function automatic void m_access();
        int w;
        m_rv = 1'b1;
        m_rdata = 32'd0;
        m_err = (m_addr % 4 != 0) || (m_addr >= DEPTH * 4);
        if (!m_err) begin
            w = int'(m_addr / 4);
            if (m_we) begin
                for (int i = 0; i < 4; i++)
                    if (m_wstrb[i]) m_mem[w][8*i +: 8] = m_wdata[8*i +: 8];
            end else begin
                m_rdata = m_mem[w];
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pend = 0; m_rv = 0; m_ready = 0; m_busy = 0;
            m_err = 0; m_rdata = 0;
        end else if (m_pend) begin
            if (m_rv) begin
                if (rsp_ready) begin
                    m_pend = 0; m_rv = 0; m_busy = 0; m_ready = 1;
                end
            end else if (cyc == m_at) begin
                m_access();
            end
        end else if (m_ready && req_valid) begin
            m_we = req_we; m_addr = req_addr;
            m_wdata = req_wdata; m_wstrb = req_wstrb;
            m_pend = 1; m_busy = 1; m_ready = 0;
            m_at = cyc + LAT;
            if (LAT == 0) m_access();
        end else begin
            m_ready = 1;
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(m_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check("busy", 32'(busy), 32'(m_busy));
        if (m_rv) begin
            check("rsp_err", 32'(rsp_err), 32'(m_err));
            check("rsp_rdata", rsp_rdata, m_rdata);
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         output int acc);
        req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
        req_valid = 1'b1;
        acc = -1;
        for (int t = 0; t < 64; t++) begin
            if (req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
    endtask

    task automatic collect(input int hold, output logic [31:0] d,
                           output logic e, output int vcyc);
        rsp_ready = 1'b0;
        vcyc = -1;
        d = 32'd0;
        e = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (rsp_valid) begin
                vcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (vcyc < 0) begin
            check("rsp_timeout", 32'd0, 32'd1);
        end else begin
            d = rsp_rdata;
            e = rsp_err;
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
            req_valid = 1'b0;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] d, output logic e, output int lat);
        int acc, vc;
        issue(we, addr, data, strb, acc);
        collect(0, d, e, vc);
        lat = vc - acc;
    endtask

    task automatic b_run(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, output int acc,
                         output int rsp, output logic [31:0] rd);
        b_req_we = we; b_req_addr = addr; b_req_wdata = data;
        b_req_wstrb = 4'hf; b_req_valid = 1'b1;
        acc = -1; rsp = -1; rd = 32'd0;
        for (int t = 0; t < 64; t++) begin
            if (b_req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (b_rsp_valid) begin
                rsp = cyc;
                rd = b_rsp_rdata;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0 || rsp < 0) check("b_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat, acc, vc;
        int          a1, r1, a2, r2;
        logic [31:0] d1, d2;

        reset = 1; req_valid = 0; req_we = 0; req_addr = 0;
        req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0;
        b_req_wdata = 0; b_req_wstrb = 0; b_rsp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) xact(1, 32'(i * 4), 0, 4'hf, d, e, lat);

        xact(1, 32'h0, 32'h4, 4'hf, d, e, lat);
        xact(0, 32'h0, 0, 4'h0, d, e, lat);
        check("t1_rdata", d, 32'h4);
        check("t1_err", 32'(e), 32'd0);
        check("t1_latency", 32'(lat), 32'd3);

        xact(1, 32'h8, 32'h3, 4'hf, d, e, lat);
        check("t2_store_rdata", d, 32'h0);
        xact(0, 32'h8, 0, 4'h0, d, e, lat);
        check("t2_raw", d, 32'h3);
        xact(1, 32'h8, 32'hAABBCCDD, 4'b0101, d, e, lat);
        xact(0, 32'h8, 0, 4'h0, d, e, lat);
        check("t2_strobe", d, 32'h00BB00DD);
        xact(1, 32'h8, 32'hFFFFFFFF, 4'b0000, d, e, lat);
        check("t2_nostrb_err", 32'(e), 32'd0);
        xact(0, 32'h8, 0, 4'h0, d, e, lat);
        check("t2_nostrb", d, 32'h00BB00DD);

        xact(1, 32'h4, 32'h8, 4'hf, d, e, lat);
        issue(0, 32'h4, 0, 4'h0, acc);
        req_valid = 1; req_we = 1; req_addr = 32'h10;
        req_wdata = 32'h12345678; req_wstrb = 4'hf;
        collect(5, d, e, vc);
        check("t3_rdata", d, 32'h8);
        @(negedge clk);
        check("t3_one_rsp", 32'(rsp_valid), 32'd0);
        check("t3_busy_clear", 32'(busy), 32'd0);
        @(posedge clk); #1;
        xact(0, 32'h10, 0, 4'h0, d, e, lat);
        check("t3_no_store", d, 32'h0);

        xact(0, 32'h6, 0, 4'h0, d, e, lat);
        check("t4_mis_err", 32'(e), 32'd1);
        check("t4_mis_rdata", d, 32'h0);
        check("t4_mis_lat", 32'(lat), 32'd3);
        xact(1, 32'h400, 32'hDEADBEEF, 4'hf, d, e, lat);
        check("t4_oor_err", 32'(e), 32'd1);
        check("t4_oor_rdata", d, 32'h0);
        xact(0, 32'h3FC, 0, 4'h0, d, e, lat);
        check("t4_mem255", d, 32'h0);
        xact(0, 32'h0, 0, 4'h0, d, e, lat);
        check("t4_mem0", d, 32'h4);

        xact(1, 32'hC, 32'h8, 4'hf, d, e, lat);
        issue(1, 32'hC, 32'h11111111, 4'hf, acc);
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        check("t5_ready", 32'(req_ready), 32'd1);
        xact(0, 32'hC, 0, 4'h0, d, e, lat);
        check("t5_mem3", d, 32'h8);

        for (int n = 0; n < 300; n++) begin
            int r;
            logic [31:0] a;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 63)) * 4;
            else             a = $urandom;
            issue(1'($urandom), a, $urandom, 4'($urandom), acc);
            req_valid = 1'($urandom);
            collect($urandom_range(0, 3), d, e, vc);
        end

        @(posedge clk); #1;
        b_run(1, 32'h0, 32'h55, a1, r1, d1);
        @(posedge clk); #1;
        b_run(1, 32'h4, 32'h66, a1, r1, d1);
        @(posedge clk); #1;
        b_run(0, 32'h0, 0, a1, r1, d1);
        b_run(0, 32'h4, 0, a2, r2, d2);
        check("t6_lat1", 32'(r1 - a1), 32'd1);
        check("t6_lat2", 32'(r2 - a2), 32'd1);
        check("t6_spacing", 32'(a2 - a1), 32'd2);
        check("t6_data1", d1, 32'h55);
        check("t6_data2", d2, 32'h66);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
